// File: rtl/rf_writeback_unit_pkg.sv
// rtl/rf_writeback_unit_pkg.sv - shared widths and write-request type for the write-back unit
package rf_writeback_unit_pkg;
  localparam int WB_XLEN = 32;
  localparam int WB_NREG = 32;
  localparam int WB_AW   = $clog2(WB_NREG);

  typedef logic [WB_AW-1:0] reg_addr_t;

  typedef struct packed {
    reg_addr_t            rd;
    logic [WB_XLEN-1:0]   data;
  } wb_req_t;
endpackage

// File: rtl/rf_writeback_unit_scoreboard.sv
// rtl/rf_writeback_unit_scoreboard.sv - busy bitmap of in-flight destinations with two read ports
module wb_scoreboard #(
  parameter int NREG = 32,
  parameter int AW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          set_valid,
  input  logic [AW-1:0] set_rd,
  input  logic          clr_valid,
  input  logic [AW-1:0] clr_rd,
  input  logic [AW-1:0] rd_a1,
  input  logic [AW-1:0] rd_a2,
  output logic          a1_busy,
  output logic          a2_busy
);
  logic [NREG-1:0] busy_q, busy_d;

  // Set is applied after clear so a reissued destination stays busy.
  always_comb begin
    busy_d = busy_q;
    if (clr_valid) busy_d[clr_rd] = 1'b0;
    if (set_valid) busy_d[set_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) busy_q <= '0;
    else      busy_q <= busy_d;
  end

  assign a1_busy = busy_q[rd_a1];
  assign a2_busy = busy_q[rd_a2];
endmodule

// File: rtl/rf_writeback_unit.sv
// rtl/rf_writeback_unit.sv - register-file write-port arbiter, ALU hold buffer and scoreboard
// Optional operand bypass from the current write is enabled by WB_BYPASS_EN.
module rf_writeback_unit
  import rf_writeback_unit_pkg::*;
#(
  parameter int XLEN = WB_XLEN,
  parameter int NREG = WB_NREG
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    iss_valid,
  input  logic [$clog2(NREG)-1:0] iss_rd,
  input  logic                    alu_valid,
  output logic                    alu_ready,
  input  logic [$clog2(NREG)-1:0] alu_rd,
  input  logic [XLEN-1:0]         alu_data,
  input  logic                    ld_valid,
  input  logic [$clog2(NREG)-1:0] ld_rd,
  input  logic [XLEN-1:0]         ld_data,
  output logic                    rf_we,
  output logic [$clog2(NREG)-1:0] rf_waddr,
  output logic [XLEN-1:0]         rf_wdata,
  input  logic [$clog2(NREG)-1:0] rd_a1,
  input  logic [$clog2(NREG)-1:0] rd_a2,
  output logic                    a1_busy,
  output logic                    a2_busy
`ifdef WB_BYPASS_EN
  ,
  output logic                    fwd1_valid,
  output logic                    fwd2_valid,
  output logic [XLEN-1:0]         fwd1_data,
  output logic [XLEN-1:0]         fwd2_data
`endif
);
  localparam int AW = $clog2(NREG);

  wb_req_t          buf_q, buf_d, wr_req;
  logic             buf_full_q, buf_full_d, wr_valid;
  logic             rf_we_q;
  logic [AW-1:0]    rf_waddr_q;
  logic [XLEN-1:0]  rf_wdata_q;
  logic             sb_a1_busy, sb_a2_busy;

  assign alu_ready = !buf_full_q;

  // Loads always win; an ALU result accepted under a load is parked until the port frees up.
  always_comb begin
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    wr_valid   = 1'b0;
    wr_req     = '0;
    if (ld_valid) begin
      wr_valid    = 1'b1;
      wr_req.rd   = ld_rd;
      wr_req.data = ld_data;
      if (alu_valid && !buf_full_q) begin
        buf_full_d = 1'b1;
        buf_d.rd   = alu_rd;
        buf_d.data = alu_data;
      end
    end else if (buf_full_q) begin
      wr_valid   = 1'b1;
      wr_req     = buf_q;
      buf_full_d = 1'b0;
    end else if (alu_valid) begin
      wr_valid    = 1'b1;
      wr_req.rd   = alu_rd;
      wr_req.data = alu_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      rf_we_q    <= wr_valid && (wr_req.rd != '0);
      if (wr_valid) begin
        rf_waddr_q <= wr_req.rd;
        rf_wdata_q <= wr_req.data;
      end
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;

  wb_scoreboard #(.NREG(NREG)) u_sb (
    .clk       (clk),
    .rst       (rst),
    .set_valid (iss_valid),
    .set_rd    (iss_rd),
    .clr_valid (wr_valid),
    .clr_rd    (wr_req.rd),
    .rd_a1     (rd_a1),
    .rd_a2     (rd_a2),
    .a1_busy   (sb_a1_busy),
    .a2_busy   (sb_a2_busy)
  );

`ifdef WB_BYPASS_EN
  assign fwd1_valid = rf_we_q && (rd_a1 == rf_waddr_q) && (rd_a1 != '0);
  assign fwd2_valid = rf_we_q && (rd_a2 == rf_waddr_q) && (rd_a2 != '0);
  assign fwd1_data  = rf_wdata_q;
  assign fwd2_data  = rf_wdata_q;
  assign a1_busy    = sb_a1_busy && !fwd1_valid;
  assign a2_busy    = sb_a2_busy && !fwd2_valid;
`else
  // Without bypass decode must also wait out the cycle the register file is being written.
  assign a1_busy = sb_a1_busy || (rf_we_q && (rd_a1 == rf_waddr_q));
  assign a2_busy = sb_a2_busy || (rf_we_q && (rd_a2 == rf_waddr_q));
`endif
endmodule
